sprite_plotter: RTL and testbench

Parametrised rectangle-sprite plotter that sits between the game-logic blocks (ball, paddle, brick position generators) and the 160x120 VGA adapter's pixel-write port. On a start request it erases the sprite's previously drawn rectangle with the background colour, then draws it at the new position, one pixel per clock. It generalises the fixed single-object ball draw path to any sprite size, colour and screen bound, and adds hide, clipping and a busy/done handshake.

---
 rtl/sprite_plotter.sv | 222 ++++++++++++++++++++++
 tb/tb_sprite_plotter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// -----------------------------------------------------------------------------
// sprite_plotter
//
// Rectangle-sprite plotter feeding the pixel-write port of a VGA adapter.
// A start request latches a new position, colour and hide flag. The plotter
// first erases the rectangle it drew last time, using the background colour,
// and only if that rectangle is still on screen. It then draws the sprite at
// the new position, one pixel per clock, unless the request was a hide.
// Pixels whose coordinate falls past the visible area are suppressed, but the
// scan still spends the cycle, so every pass has a fixed length.
//
// Ports
//   clk_i         system clock, all state changes on the rising edge
//   reset_i       asynchronous active-high reset
//   start_i       request strobe, sampled only while idle
//   hide_i        sampled with start_i: 1 = erase only
//   new_x_i       top-left x of the new position
//   new_y_i       top-left y of the new position
//   colour_i      sprite colour, sampled with start_i
//   busy_o        high while a request is in progress
//   done_o        one-cycle pulse in the final cycle of a request
//   x_o, y_o      pixel coordinate to the adapter
//   vga_colour_o  pixel colour to the adapter
//   plot_o        pixel write strobe to the adapter
// -----------------------------------------------------------------------------
module sprite_plotter #(
    parameter int          X_W       = 8,
    parameter int          Y_W       = 7,
    parameter int          SPR_W     = 4,
    parameter int          SPR_H     = 4,
    parameter int          X_MAX     = 159,
    parameter int          Y_MAX     = 119,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            hide_i,
    input  logic [X_W-1:0]  new_x_i,
    input  logic [Y_W-1:0]  new_y_i,
    input  logic [2:0]      colour_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [X_W-1:0]  x_o,
    output logic [Y_W-1:0]  y_o,
    output logic [2:0]      vga_colour_o,
    output logic            plot_o
);

    // Counter widths. A one-pixel dimension still gets a one-bit counter.
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
    localparam logic [X_W:0]  X_LIM    = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0]  Y_LIM    = (Y_W + 1)'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [X_W-1:0]  old_x_q, old_x_d;
    logic [Y_W-1:0]  old_y_q, old_y_d;
    logic            shown_q, shown_d;
    logic [X_W-1:0]  req_x_q, req_x_d;
    logic [Y_W-1:0]  req_y_q, req_y_d;
    logic [2:0]      req_col_q, req_col_d;
    logic            req_hide_q, req_hide_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    logic            last_col_s;
    logic            last_px_s;
    logic [X_W-1:0]  base_x_s;
    logic [Y_W-1:0]  base_y_s;
    logic [X_W:0]    sum_x_s;
    logic [Y_W:0]    sum_y_s;

    assign last_col_s = (col_q == COL_LAST);
    assign last_px_s  = last_col_s && (row_q == ROW_LAST);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            old_x_q    <= '0;
            old_y_q    <= '0;
            shown_q    <= 1'b0;
            req_x_q    <= '0;
            req_y_q    <= '0;
            req_col_q  <= 3'b000;
            req_hide_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            shown_q    <= shown_d;
            req_x_q    <= req_x_d;
            req_y_q    <= req_y_d;
            req_col_q  <= req_col_d;
            req_hide_q <= req_hide_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    // Next-state logic: request capture, scan counters and bookkeeping of
    // which rectangle is currently on screen.
    always_comb begin
        state_d    = state_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        shown_d    = shown_q;
        req_x_d    = req_x_q;
        req_y_d    = req_y_q;
        req_col_d  = req_col_q;
        req_hide_d = req_hide_q;
        col_d      = col_q;
        row_d      = row_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    req_x_d    = new_x_i;
                    req_y_d    = new_y_i;
                    req_col_d  = colour_i;
                    req_hide_d = hide_i;
                    col_d      = '0;
                    row_d      = '0;
                    if (shown_q) begin
                        state_d = S_ERASE;
                    end else if (!hide_i) begin
                        state_d = S_DRAW;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ERASE, S_DRAW: begin
                // Row-major scan: col runs fastest, both wrap after the last pixel.
                if (last_px_s) begin
                    col_d = '0;
                    row_d = '0;
                    if ((state_q == S_ERASE) && !req_hide_q) begin
                        state_d = S_DRAW;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (last_col_s) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end

            S_DONE: begin
                // A hide leaves nothing on screen; a draw becomes the next erase target.
                if (req_hide_q) begin
                    shown_d = 1'b0;
                end else begin
                    shown_d = 1'b1;
                    old_x_d = req_x_q;
                    old_y_d = req_y_q;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel decode from registered state. Sums carry one extra bit so that
    // coordinates past the screen edge are detected rather than wrapped.
    always_comb begin
        base_x_s     = req_x_q;
        base_y_s     = req_y_q;
        vga_colour_o = 3'b000;
        case (state_q)
            S_ERASE: begin
                base_x_s     = old_x_q;
                base_y_s     = old_y_q;
                vga_colour_o = BG_COLOUR;
            end
            S_DRAW: begin
                vga_colour_o = req_col_q;
            end
            default: begin
                vga_colour_o = 3'b000;
            end
        endcase

        sum_x_s = {1'b0, base_x_s} + (X_W + 1)'(col_q);
        sum_y_s = {1'b0, base_y_s} + (Y_W + 1)'(row_q);

        if ((state_q == S_ERASE) || (state_q == S_DRAW)) begin
            x_o    = sum_x_s[X_W-1:0];
            y_o    = sum_y_s[Y_W-1:0];
            plot_o = (sum_x_s <= X_LIM) && (sum_y_s <= Y_LIM);
        end else begin
            x_o    = '0;
            y_o    = '0;
            plot_o = 1'b0;
        end

        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_sprite_plotter.sv
module tb_sprite_plotter;

    localparam int SW = 4;
    localparam int SH = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       hide;
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic [2:0] colour;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] vga_colour;
    logic       plot;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the screen currently holds.
    logic       m_shown;
    int         m_ox;
    int         m_oy;

    typedef struct packed {
        logic       pix;
        logic       busy;
        logic       done;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
    } exp_t;

    sprite_plotter dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .hide_i       (hide),
        .new_x_i      (new_x),
        .new_y_i      (new_y),
        .colour_i     (colour),
        .busy_o       (busy),
        .done_o       (done),
        .x_o          (x),
        .y_o          (y),
        .vga_colour_o (vga_colour),
        .plot_o       (plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pixel for one rectangle cell: coordinates by plain integer
    // arithmetic, visible only if inside the 160x120 screen.
    function automatic exp_t pixel(input int bx, input int by, input int c, input int r,
                                   input logic [2:0] col);
        exp_t e;
        int px;
        int py;
        px       = bx + c;
        py       = by + r;
        e.pix    = 1'b1;
        e.busy   = 1'b1;
        e.done   = 1'b0;
        e.plot   = (px <= 159) && (py <= 119);
        e.x      = px[7:0];
        e.y      = py[6:0];
        e.col    = col;
        return e;
    endfunction

    // Issue one request and check every cycle until the plotter is idle again.
    // poke >= 0 pulses start (with other coordinates) in that cycle of the run.
    task automatic run_req(input string name, input int nx, input int ny,
                           input logic [2:0] c, input logic h, input int poke);
        exp_t q[$];
        exp_t e;
        if (m_shown)
            for (int r = 0; r < SH; r++)
                for (int k = 0; k < SW; k++)
                    q.push_back(pixel(m_ox, m_oy, k, r, 3'b000));
        if (!h)
            for (int r = 0; r < SH; r++)
                for (int k = 0; k < SW; k++)
                    q.push_back(pixel(nx, ny, k, r, c));
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        q.push_back(e);
        e = '0;
        q.push_back(e);
        if (h) begin
            m_shown = 1'b0;
        end else begin
            m_shown = 1'b1;
            m_ox    = nx;
            m_oy    = ny;
        end

        start  = 1'b1;
        hide   = h;
        new_x  = nx[7:0];
        new_y  = ny[6:0];
        colour = c;
        @(posedge clk); #1;
        start  = 1'b0;
        new_x  = 8'($urandom);
        new_y  = 7'($urandom);
        colour = 3'($urandom);
        hide   = 1'($urandom);
        for (int i = 0; i < q.size(); i++) begin
            start = (i == poke) ? 1'b1 : 1'b0;
            checks++;
            if ({busy, done, plot} !== {q[i].busy, q[i].done, q[i].plot}) begin
                failures++;
                $display("FAIL %s cyc%0d ctrl busy/done/plot got %b%b%b want %b%b%b",
                         name, i + 1, busy, done, plot, q[i].busy, q[i].done, q[i].plot);
            end
            if (q[i].pix) begin
                checks++;
                if ({x, y, vga_colour} !== {q[i].x, q[i].y, q[i].col}) begin
                    failures++;
                    $display("FAIL %s cyc%0d pixel got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             name, i + 1, x, y, vga_colour, q[i].x, q[i].y, q[i].col);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        m_shown = 1'b0;
        m_ox    = 0;
        m_oy    = 0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({busy, done, plot, x, y, vga_colour} !== 21'd0) begin
            failures++;
            $display("FAIL %s outputs busy=%b done=%b plot=%b x=%0d y=%0d col=%b want all 0",
                     name, busy, done, plot, x, y, vga_colour);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_zero("reset");
    endtask

    task automatic test_first_draw();
        run_req("first_draw", 10, 20, 3'b100, 1'b0, -1);
    endtask

    task automatic test_move();
        run_req("move", 11, 20, 3'b010, 1'b0, -1);
    endtask

    task automatic test_clip();
        apply_reset();
        run_req("clip", 158, 118, 3'b111, 1'b0, -1);
    endtask

    task automatic test_hide();
        run_req("hide_setup", 40, 40, 3'b011, 1'b0, -1);
        run_req("hide_erase", 0, 0, 3'b101, 1'b1, -1);
        run_req("hide_again", 5, 5, 3'b101, 1'b1, -1);
    endtask

    task automatic test_start_while_busy();
        run_req("busy_ignore", 60, 30, 3'b110, 1'b0, 20);
        run_req("busy_ignore2", 61, 31, 3'b001, 1'b0, 5);
    endtask

    task automatic test_reset_mid_draw();
        int cyc;
        start  = 1'b1;
        hide   = 1'b0;
        new_x  = 8'd70;
        new_y  = 7'd50;
        colour = 3'b101;
        @(posedge clk); #1;
        start = 1'b0;
        // Sprite is shown from before, so the erase pass runs first; wait until
        // the draw pass is under way, bounded by a cycle budget.
        cyc = 0;
        while (!(plot && vga_colour == 3'b101) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 100) begin
            failures++;
            $display("FAIL reset_mid wait for draw pass got timeout want draw pixels");
        end
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_mid");
        @(posedge clk); #1;
        reset   = 1'b0;
        m_shown = 1'b0;
        m_ox    = 0;
        m_oy    = 0;
        check_zero("reset_mid_idle");
        run_req("after_reset", 90, 60, 3'b010, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_req("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    3'($urandom), ($urandom_range(0, 3) == 0), -1);
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        hide   = 1'b0;
        new_x  = 8'd0;
        new_y  = 7'd0;
        colour = 3'b000;
        m_shown = 1'b0;
        m_ox    = 0;
        m_oy    = 0;
        #2;
        test_reset();
        test_first_draw();
        test_move();
        test_clip();
        test_hide();
        test_start_while_busy();
        test_reset_mid_draw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
